// File: rtl/somador_bcd_pkg.sv
// rtl/somador_bcd_pkg.sv - shared states, segment codes and digit-count helper for somador_bcd_seq
package somador_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decimal digits needed to show the largest s-bit unsigned value
  function automatic int bcd_digits(input int s);
    longint unsigned v;
    int n;
    v = (64'd1 << s) - 64'd1;
    n = 1;
    v = v / 64'd10;
    while (v != 64'd0) begin
      n++;
      v = v / 64'd10;
    end
    return n;
  endfunction

endpackage

// File: rtl/somador_bcd_seq_dec_7seg.sv
// rtl/somador_bcd_seq_dec_7seg.sv - BCD digit to active-low 7-segment decoder with blanking
module dec_7seg
  import somador_bcd_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blank wins; non-decimal codes also go dark rather than show garbage
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/somador_bcd_seq.sv
// rtl/somador_bcd_seq.sv - sequential adder/accumulator with double-dabble BCD and 7-seg outputs (option: LEADING_ZERO_BLANK_EN)
module somador_bcd_seq
  import somador_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic                  mode,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int S   = WIDTH + 1;
  localparam int SRW = 4 * DIGITS + S;
  localparam int CW  = $clog2(S + 1);

  if (DIGITS < bcd_digits(S)) begin : g_digits_check
    $error("somador_bcd_seq: DIGITS too small to display a WIDTH+1 bit result");
  end

  state_e              state_q, state_d;
  logic [S-1:0]        acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [SRW-1:0]      sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;

  logic [S-1:0]        sum_ab;
  logic [S:0]          sum_acc;
  logic [S-1:0]        result;
  logic [SRW-1:0]      adj;
  logic [DIGITS-1:0]   blank;

  // a+b never loses a bit in S; the accumulator sum keeps one extra bit for the wrap flag
  assign sum_ab  = {1'b0, a} + {1'b0, b};
  assign sum_acc = {1'b0, acc_q} + {2'b00, a};

  // Double-dabble correction: each BCD nibble >= 5 gets +3 before the shift
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[S+4*i +: 4] >= 4'd5) begin
        adj[S+4*i +: 4] = sr_q[S+4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state logic for the IDLE -> SHIFT x S -> DONE sequence
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    result  = sum_ab;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (mode) begin
            result = sum_acc[S-1:0];
            acc_d  = sum_acc[S-1:0];
            if (sum_acc[S]) begin
              ovf_d = 1'b1;
            end
          end else begin
            result = sum_ab;
            ovf_d  = 1'b0;
          end
          sr_d    = {{(4*DIGITS){1'b0}}, result};
          cnt_d   = CW'(S);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = adj << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        disp_d  = sr_q[SRW-1:S];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset also aborts any conversion in flight
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank zero digits above the most significant non-zero one; units always shown
  always_comb begin
    logic lead;
    blank = '0;
    lead  = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (disp_q[4*i +: 4] != 4'd0) begin
        lead = 1'b0;
      end
      blank[i] = lead;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_dec
    dec_7seg u_dec (
      .bcd_i   (disp_q[4*i +: 4]),
      .blank_i (blank[i]),
      .seg_o   (HEX[7*i +: 7])
    );
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule
